// File: rtl/rx_frame_chk_if.sv
// rtl/rx_frame_chk_if.sv - bit-sample and frame-result bundle for rx_frame_chk
interface rx_frame_chk_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  frame_start;
  logic                  bit_valid;
  logic                  sampled_bit;
  logic                  par_en;
  logic                  par_type;
  logic [DATA_WIDTH-1:0] p_data;
  logic                  data_valid;
  logic                  strt_glitch;
  logic                  par_err;
  logic                  stp_err;
  logic                  busy;

  modport master (
    output frame_start, bit_valid, sampled_bit, par_en, par_type,
    input  p_data, data_valid, strt_glitch, par_err, stp_err, busy
  );

  modport slave (
    input  frame_start, bit_valid, sampled_bit, par_en, par_type,
    output p_data, data_valid, strt_glitch, par_err, stp_err, busy
  );
endinterface

// File: rtl/rx_frame_chk.sv
// rtl/rx_frame_chk.sv - UART RX frame checker: start/parity/stop checks and data deserialisation
module rx_frame_chk #(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1
) (
  input  logic           CLK,
  input  logic           RST,
  rx_frame_chk_if.slave  rx
);
  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state, state_nxt;
  logic [CW-1:0]         cnt, cnt_nxt;
  logic [DATA_WIDTH-1:0] shreg, shreg_nxt;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_nxt;
  logic                  par_en_q, par_en_nxt;
  logic                  par_type_q, par_type_nxt;
  logic                  dv_q, dv_nxt;
  logic                  sg_q, sg_nxt;
  logic                  pe_q, pe_nxt;
  logic                  se_q, se_nxt;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= IDLE;
      cnt        <= '0;
      shreg      <= '0;
      p_data_q   <= '0;
      par_en_q   <= 1'b0;
      par_type_q <= 1'b0;
      dv_q       <= 1'b0;
      sg_q       <= 1'b0;
      pe_q       <= 1'b0;
      se_q       <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      shreg      <= shreg_nxt;
      p_data_q   <= p_data_nxt;
      par_en_q   <= par_en_nxt;
      par_type_q <= par_type_nxt;
      dv_q       <= dv_nxt;
      sg_q       <= sg_nxt;
      pe_q       <= pe_nxt;
      se_q       <= se_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    shreg_nxt    = shreg;
    p_data_nxt   = p_data_q;
    par_en_nxt   = par_en_q;
    par_type_nxt = par_type_q;
    dv_nxt       = 1'b0;
    sg_nxt       = sg_q;
    pe_nxt       = pe_q;
    se_nxt       = se_q;
    case (state)
      IDLE: begin
        if (rx.frame_start) begin
          state_nxt    = START;
          cnt_nxt      = '0;
          sg_nxt       = 1'b0;
          pe_nxt       = 1'b0;
          se_nxt       = 1'b0;
          par_en_nxt   = rx.par_en;
          par_type_nxt = rx.par_type;
        end
      end
      START: begin
        if (rx.bit_valid) begin
          if (rx.sampled_bit) begin
            sg_nxt    = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = DATA;
          end
        end
      end
      DATA: begin
        if (rx.bit_valid) begin
          shreg_nxt = {rx.sampled_bit, shreg[DATA_WIDTH-1:1]};
          if (cnt == CW'(DATA_WIDTH - 1)) begin
            cnt_nxt   = '0;
            state_nxt = par_en_q ? PARITY : STOP;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      PARITY: begin
        if (rx.bit_valid) begin
          pe_nxt    = (rx.sampled_bit != ((^shreg) ^ par_type_q));
          state_nxt = STOP;
        end
      end
      STOP: begin
        if (rx.bit_valid) begin
          if (!rx.sampled_bit) se_nxt = 1'b1;
          cnt_nxt = cnt + 1'b1;
          if (cnt == CW'(STOP_BITS - 1)) begin
            state_nxt = IDLE;
            // se_q is the pre-edge value, so an earlier low stop bit still blocks delivery
            if (!pe_q && rx.sampled_bit && !se_q) begin
              p_data_nxt = shreg;
              dv_nxt     = 1'b1;
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign rx.p_data      = p_data_q;
  assign rx.data_valid  = dv_q;
  assign rx.strt_glitch = sg_q;
  assign rx.par_err     = pe_q;
  assign rx.stp_err     = se_q;
  assign rx.busy        = (state != IDLE);
endmodule
